// File: rtl/wbi_dcg_ctrl_if.sv
// Bundles the configuration, request/ready handshake and status vectors
// exchanged between the interconnect and the dynamic clock-gate controller.
interface wbi_dcg_ctrl_if #(
    parameter int NCH = 8
);
    logic [31:0]    cfg_dcg_ctrl;
    logic [NCH-1:0] slv_req;
    logic [NCH-1:0] slv_rdy;
    logic [NCH-1:0] clk_en;
    logic [7:0]     stat_reg_req;
    logic [7:0]     stat_clk_gate;

    modport master (
        output cfg_dcg_ctrl,
        output slv_req,
        input  slv_rdy,
        input  clk_en,
        input  stat_reg_req,
        input  stat_clk_gate
    );

    modport slave (
        input  cfg_dcg_ctrl,
        input  slv_req,
        output slv_rdy,
        output clk_en,
        output stat_reg_req,
        output stat_clk_gate
    );
endinterface

// File: rtl/wbi_dcg_ctrl.sv
// Per-slave dynamic clock-gate controller: gates each slave clock after T idle
// cycles and re-enables it on demand, holding the request off until settled.
module wbi_dcg_ctrl #(
    parameter int NCH      = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic          mclk,
    input  logic          reset,
    wbi_dcg_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } dcg_state_e;

    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYC - 1);

    logic [7:0]     gate_en;
    logic [7:0]     idle_tmo;
    logic           unused_cfg;

    dcg_state_e     state_q [NCH];
    dcg_state_e     state_d [NCH];
    logic [7:0]     idle_q  [NCH];
    logic [7:0]     idle_d  [NCH];
    logic [3:0]     wake_q  [NCH];
    logic [3:0]     wake_d  [NCH];

    logic [NCH-1:0] clk_en_q;
    logic [NCH-1:0] rdy_q;
    logic [NCH-1:0] gate_q;
    logic [NCH-1:0] req_q;
    logic [7:0]     stat_req_ext;
    logic [7:0]     stat_gate_ext;

    assign gate_en    = bus.cfg_dcg_ctrl[7:0];
    assign idle_tmo   = bus.cfg_dcg_ctrl[23:16];
    assign unused_cfg = ^{bus.cfg_dcg_ctrl[31:24], bus.cfg_dcg_ctrl[15:8]};

    // A request always beats the idle timeout; the wake sequence is never
    // aborted so the slave clock is guaranteed settled before slv_rdy rises.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            idle_d[i]  = idle_q[i];
            wake_d[i]  = wake_q[i];
            case (state_q[i])
                ST_RUN: begin
                    if (gate_en[i] && (idle_tmo != 8'd0) && !bus.slv_req[i]) begin
                        if (idle_q[i] == (idle_tmo - 8'd1)) begin
                            state_d[i] = ST_GATED;
                            idle_d[i]  = 8'd0;
                        end else begin
                            idle_d[i] = idle_q[i] + 8'd1;
                        end
                    end else begin
                        idle_d[i] = 8'd0;
                    end
                end
                ST_GATED: begin
                    if (bus.slv_req[i] || !gate_en[i]) begin
                        state_d[i] = ST_WAKE;
                        wake_d[i]  = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (wake_q[i] == 4'd0) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        wake_d[i] = wake_q[i] - 4'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_RUN;
                idle_q[i]  <= 8'd0;
                wake_q[i]  <= 4'd0;
            end
            clk_en_q <= '1;
            rdy_q    <= '1;
            gate_q   <= '0;
            req_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                idle_q[i]   <= idle_d[i];
                wake_q[i]   <= wake_d[i];
                clk_en_q[i] <= (state_d[i] != ST_GATED);
                rdy_q[i]    <= (state_d[i] == ST_RUN);
                gate_q[i]   <= (state_d[i] == ST_GATED);
            end
            req_q <= bus.slv_req;
        end
    end

    always_comb begin
        stat_req_ext             = 8'd0;
        stat_gate_ext            = 8'd0;
        stat_req_ext[NCH-1:0]    = req_q;
        stat_gate_ext[NCH-1:0]   = gate_q;
    end

    assign bus.clk_en        = clk_en_q;
    assign bus.slv_rdy       = rdy_q;
    assign bus.stat_reg_req  = stat_req_ext;
    assign bus.stat_clk_gate = stat_gate_ext;

endmodule

// File: tb/tb_wbi_dcg_ctrl.sv
// Bench for wbi_dcg_ctrl: directed scenarios plus random traffic, compared each
// cycle against a time-based model of gating, waking and readiness.
module tb_wbi_dcg_ctrl;

    localparam int WAKE_CYC = 2;

    logic mclk  = 1'b0;
    logic reset = 1'b0;

    wbi_dcg_ctrl_if #(.NCH(8)) bus ();

    wbi_dcg_ctrl #(
        .NCH      (8),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 mclk = ~mclk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    bit         gated    [8];
    int         idle_run [8];
    int         ready_at [8];
    logic [7:0] prev_req;

    logic [7:0]  rreq;
    logic [31:0] rcfg;
    int          tsel;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                     tag, cyc, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) begin
            gated[i]    = 1'b0;
            idle_run[i] = 0;
            ready_at[i] = cyc;
        end
        prev_req = 8'h00;
    endfunction

    // A channel is waking while the current edge has not passed its ready time;
    // the edge that completes the wake does not count as an idle cycle.
    function automatic void modelStep(input logic [31:0] cfg, input logic [7:0] req);
        int t;
        t = int'(cfg[23:16]);
        cyc++;
        for (int i = 0; i < 8; i++) begin
            if (gated[i]) begin
                if (req[i] || !cfg[i]) begin
                    gated[i]    = 1'b0;
                    ready_at[i] = cyc + WAKE_CYC;
                    idle_run[i] = 0;
                end
            end else if (cyc <= ready_at[i]) begin
                idle_run[i] = 0;
            end else if (cfg[i] && t != 0 && !req[i]) begin
                if (idle_run[i] == t - 1) begin
                    gated[i]    = 1'b1;
                    idle_run[i] = 0;
                end else begin
                    idle_run[i] = (idle_run[i] + 1) % 256;
                end
            end else begin
                idle_run[i] = 0;
            end
        end
        prev_req = req;
    endfunction

    task automatic compareAll(input string phase);
        logic [7:0] exp_clk, exp_rdy, exp_gate;
        for (int i = 0; i < 8; i++) begin
            exp_clk[i]  = !gated[i];
            exp_rdy[i]  = !gated[i] && (cyc >= ready_at[i]);
            exp_gate[i] = gated[i];
        end
        checkOutput({phase, ".clk_en"},   32'(bus.clk_en),        32'(exp_clk));
        checkOutput({phase, ".slv_rdy"},  32'(bus.slv_rdy),       32'(exp_rdy));
        checkOutput({phase, ".gate"},     32'(bus.stat_clk_gate), 32'(exp_gate));
        checkOutput({phase, ".reg_req"},  32'(bus.stat_reg_req),  32'(prev_req));
    endtask

    task automatic applyStimulus(input string phase, input logic [31:0] cfg,
                                 input logic [7:0] req, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            bus.cfg_dcg_ctrl = cfg;
            bus.slv_req      = req;
            @(posedge mclk);
            modelStep(cfg, req);
            #1;
            compareAll(phase);
        end
    endtask

    initial begin
        bus.cfg_dcg_ctrl = 32'h0;
        bus.slv_req      = 8'h00;
        #2 reset = 1'b1;
        #1;
        modelReset();
        compareAll("reset");
        @(posedge mclk);
        #3 reset = 1'b0;

        applyStimulus("gate16", 32'h0010_0001, 8'h00, 20);
        applyStimulus("wake",   32'h0010_0001, 8'h01, 6);
        applyStimulus("regate", 32'h0010_0001, 8'h00, 18);

        applyStimulus("race_wake", 32'h0004_0001, 8'h01, 4);
        applyStimulus("race_idle", 32'h0004_0001, 8'h00, 3);
        applyStimulus("race_req",  32'h0004_0001, 8'h01, 2);
        applyStimulus("race_gate", 32'h0004_0001, 8'h00, 6);

        applyStimulus("dis_gate", 32'h0004_0008, 8'h00, 6);
        applyStimulus("dis_off",  32'h0004_0000, 8'h00, 12);

        applyStimulus("t0_all", 32'h0000_00FF, 8'h00, 20);
        applyStimulus("t0_req", 32'h0000_00FF, 8'h01, 4);
        applyStimulus("t0_idle", 32'hA500_5AFF, 8'h00, 20);

        applyStimulus("multi_1",  32'h0008_00FF, 8'h02, 3);
        applyStimulus("multi_2",  32'h0008_00FF, 8'h00, 2);
        applyStimulus("multi_5",  32'h0008_00FF, 8'h20, 3);
        applyStimulus("multi_i",  32'h0008_00FF, 8'h00, 15);

        applyStimulus("wrap_wk",  32'h00C8_0001, 8'h01, 4);
        applyStimulus("wrap_cnt", 32'h00C8_0001, 8'h00, 50);
        applyStimulus("wrap_dn",  32'h000A_0001, 8'h00, 215);

        applyStimulus("pre_rst",  32'h0003_00FF, 8'h00, 5);
        #2 reset = 1'b1;
        #1;
        modelReset();
        compareAll("mid_reset");
        @(posedge mclk);
        #3 reset = 1'b0;
        applyStimulus("post_rst", 32'h0003_00FF, 8'h00, 5);

        rreq = 8'h00;
        rcfg = 32'h0005_00FF;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                tsel = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
                rcfg = $urandom;
                rcfg[23:16] = 8'(tsel);
            end
            for (int i = 0; i < 8; i++) begin
                if (rreq[i]) begin
                    if ($urandom_range(0, 3) == 0) rreq[i] = 1'b0;
                end else if ($urandom_range(0, 24) == 0) begin
                    rreq[i] = 1'b1;
                end
            end
            applyStimulus("rand", rcfg, rreq, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wbi_dcg_ctrl.md
# wbi_dcg_ctrl

Per-slave dynamic clock-gate controller for the Wishbone interconnect. It consumes the dynamic clock-gate configuration word (`cfg_dcg_ctrl`) from the interconnect register block. It produces the per-slave clock enables, plus the request and clock-gate status vectors that are read back through that register block. Each channel gates its slave clock after a programmable number of idle cycles. On a new request it re-enables the clock and holds the request off with a ready handshake until the clock has settled.

## Interface
Parameters:
- `NCH`, 8: number of gated slave channels (max 8; status vectors are 8 bits wide).
- `WAKE_CYC`, 2: cycles between clock re-enable and `slv_rdy` assertion (range 1..15).

Ports:
- `mclk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_dcg_ctrl`  in  32  configuration from the register block:
  - [7:0] per-channel dynamic-gate enable.
  - [23:16] idle timeout T in cycles.
  - others reserved, ignored.
- `slv_req`  in  NCH  per-slave access request from the interconnect decoder; held high until the transfer completes.
- `slv_rdy`  out  NCH  channel clock is running and settled; the interconnect may forward the request only while this is high.
- `clk_en`  out  NCH  enable to the slave clock-gate cell (1 = clock running).
- `stat_reg_req`  out  8  registered `slv_req`; bits ≥ NCH are 0.
- `stat_clk_gate`  out  8  1 = channel currently gated; bits ≥ NCH are 0.

## Operation
- One independent FSM per channel, with states RUN, GATED and WAKE. All outputs are registered.
- **RUN:** `clk_en`=1, `slv_rdy`=1, `stat_clk_gate`=0.
  - 8-bit idle counter increments each cycle that enable=1, T≠0 and `slv_req`=0.
  - The counter clears when `slv_req`=1, enable=0 or T=0.
  - When the counter equals T−1 on an idle cycle, next state is GATED and the counter clears.
- **GATED:** `clk_en`=0, `slv_rdy`=0, `stat_clk_gate`=1.
  - If `slv_req`=1 or enable=0: next state WAKE, and the wake counter loads WAKE_CYC−1.
- **WAKE:** `clk_en`=1, `slv_rdy`=0, `stat_clk_gate`=0.
  - The wake counter decrements each cycle; at 0 the next state is RUN.
  - `slv_req` and enable are ignored in WAKE: the wake always completes.
- T=0 disables gating for all channels, but channels already GATED stay gated until a request arrives.
- A change of T while a channel is idle takes effect on the next compare. The counter is not cleared, and a counter already ≥ T waits for 8-bit wrap (documented behaviour).
- `stat_reg_req[i]` = `slv_req[i]` delayed by one cycle, in all states.

## Timing
- **Reset values:** all channels in RUN, counters 0; `clk_en`=all 1, `slv_rdy`=all 1, `stat_clk_gate`=0, `stat_reg_req`=0.
- **Gate latency:** with idle cycles 1..T sampled at edges 1..T, `clk_en` falls and `stat_clk_gate` rises after edge T, i.e. exactly T idle cycles.
- **Simultaneous events:**
  - If `slv_req` rises on the cycle the counter hits T−1, the request wins: stay RUN, counter clears.
  - If enable falls on the same cycle, stay RUN.
- **Wake latency:** `slv_req` sampled high in GATED at edge N gives `clk_en`=1 after edge N, and `slv_rdy`=1 after edge N+WAKE_CYC.
- **Handshake:**
  - `slv_rdy` never rises in the same cycle as `clk_en`.
  - `clk_en` never falls while `slv_req`=1 in RUN.
- **Reset mid-operation:** every channel returns to RUN immediately and asynchronously, so clocks are forced on.

## Test plan
- **Reset:** assert `reset` with channels gated -> `clk_en`=8'hFF, `slv_rdy`=8'hFF, both status vectors 0 immediately.
- **Gating:** cfg=32'h0010_0001 (T=16, ch0 enabled), `slv_req`=0 -> `clk_en[0]` falls after exactly 16 cycles, `stat_clk_gate`=8'h01. Channels 1-7 stay enabled.
- **Wake:** ch0 gated, WAKE_CYC=2, `slv_req[0]` pulsed high and held -> `clk_en[0]`=1 one cycle later, `slv_rdy[0]`=1 two cycles after that, `stat_reg_req[0]`=1 one cycle after `req`.
- **Race:** T=4, `slv_req[0]` rises on the 4th idle cycle -> ch0 never gates, counter restarts, and gating occurs 4 cycles after `req` drops.
- **Disable:** ch3 gated, cfg bit 3 cleared -> WAKE then RUN, `slv_rdy[3]`=1 after WAKE_CYC cycles, no further gating. Separately, T=0 with all enables set -> no channel ever gates.
- **Multi-channel:** cfg=32'h0008_00FF with staggered requests on ch1/ch5 -> each channel gates 8 cycles after its own last request, independently, and `stat_clk_gate` tracks the per-bit state.
